pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage F/D/E/M/W integer pipeline.
- Shadows the destination-register, write-enable, load and valid bits of the E, M and W stages.
- Drives operand-forwarding selects, load-use stalls, branch/jump flushes and the global freeze on data-cache miss.
- Replaces the fixed "all pipeline registers enabled by dhit" scheme.

---
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the F/D/E/M/W pipeline: combinational stage enables, flushes and forwarding selects.
// Shadow state advances one stage per enabled edge; dhit=0 freezes every enable and all shadow state.
module pipe_hazard_ctrl #(
    parameter int RA_W   = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dhit,
    input  logic             valid_d,
    input  logic [RA_W-1:0]  rs1_d,
    input  logic [RA_W-1:0]  rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [RA_W-1:0]  rd_d,
    input  logic             regwrite_d,
    input  logic             load_d,
    input  logic             redirect_m,
    output logic             en_f,
    output logic             en_d,
    output logic             en_e,
    output logic             en_m,
    output logic             en_w,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             valid_e,
    output logic             valid_m,
    output logic             valid_w,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            vld;
        logic            rw;
        logic            ld;
        logic [RA_W-1:0] rd;
    } stg_t;

    typedef struct packed {
        logic            u1;
        logic            u2;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
    } src_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stg_t e_q, e_d, m_q, m_d, w_q, w_d;
    src_t es_q, es_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic d_hit_e, d_hit_mw, load_use, raw, hazard, stall_evt, flush_evt;

    // Register 0 is hardwired zero, so it can never create a dependency.
    function automatic logic hit(input logic use_s, input logic [RA_W-1:0] s, input stg_t x);
        return use_s && (s != '0) && x.vld && x.rw && (x.rd == s);
    endfunction

    assign d_hit_e   = hit(use_rs1_d, rs1_d, e_q) || hit(use_rs2_d, rs2_d, e_q);
    assign d_hit_mw  = hit(use_rs1_d, rs1_d, m_q) || hit(use_rs2_d, rs2_d, m_q) ||
                       hit(use_rs1_d, rs1_d, w_q) || hit(use_rs2_d, rs2_d, w_q);
    assign load_use  = FWD_EN && d_hit_e && e_q.ld;
    // Without forwarding the register file is not write-through, so W also blocks.
    assign raw       = !FWD_EN && (d_hit_e || d_hit_mw);
    assign hazard    = load_use || raw;
    assign stall_evt = !reset && dhit && !redirect_m && hazard;
    assign flush_evt = !reset && dhit && redirect_m;

    always_comb begin
        en_f    = 1'b1;
        en_d    = 1'b1;
        en_e    = 1'b1;
        en_m    = 1'b1;
        en_w    = 1'b1;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!reset) begin
            if (!dhit) begin
                {en_f, en_d, en_e, en_m, en_w} = '0;
            end else if (redirect_m) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (hazard) begin
                en_f    = 1'b0;
                en_d    = 1'b0;
                flush_e = 1'b1;
            end
        end
    end

    // A load in M has no result yet; the load-use stall keeps that case from arising.
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (FWD_EN && !reset) begin
            if (hit(es_q.u1, es_q.rs1, m_q) && !m_q.ld)  fwd_a_e = 2'b10;
            else if (hit(es_q.u1, es_q.rs1, w_q))        fwd_a_e = 2'b01;
            if (hit(es_q.u2, es_q.rs2, m_q) && !m_q.ld)  fwd_b_e = 2'b10;
            else if (hit(es_q.u2, es_q.rs2, w_q))        fwd_b_e = 2'b01;
        end
    end

    always_comb begin
        e_d         = e_q;
        es_d        = es_q;
        m_d         = m_q;
        w_d         = w_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (en_e) begin
            e_d  = '{vld: valid_d & ~flush_e, rw: regwrite_d, ld: load_d, rd: rd_d};
            es_d = '{u1: use_rs1_d, u2: use_rs2_d, rs1: rs1_d, rs2: rs2_d};
            m_d  = e_q;
            w_d  = m_q;
        end
        if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q         <= '0;
            es_q        <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            es_q        <= es_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign valid_e   = e_q.vld;
    assign valid_m   = m_q.vld;
    assign valid_w   = w_q.vld;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (forwarding, no forwarding, 2-bit counters) share one stimulus stream.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic rst, dh, rdr, v;
        logic [4:0] a;
        logic ua;
        logic [4:0] b;
        logic ub;
        logic [4:0] d;
        logic w, l;
    } stim_t;

    typedef struct packed {
        logic [4:0]  en;
        logic [1:0]  fl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [2:0]  vld;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    localparam logic [4:0] EN_ALL = 5'b11111;
    localparam logic [4:0] EN_STL = 5'b00111;
    localparam logic [4:0] EN_FRZ = 5'b00000;

    logic clk = 1'b0;
    logic reset, dhit, valid_d, use_rs1_d, use_rs2_d, regwrite_d, load_d, redirect_m;
    logic [4:0] rs1_d, rs2_d, rd_d;

    logic [2:0] ef, ed, ee, em, ew, fd, fe, ve, vm, vw;
    logic [2:0][1:0] fa, fb;
    logic [1:0][15:0] sc01, fc01;
    logic [1:0] sc2, fc2;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RA_W(5), .FWD_EN(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .reset(reset), .dhit(dhit), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
        .load_d(load_d), .redirect_m(redirect_m), .en_f(ef[0]), .en_d(ed[0]), .en_e(ee[0]),
        .en_m(em[0]), .en_w(ew[0]), .flush_d(fd[0]), .flush_e(fe[0]), .fwd_a_e(fa[0]), .fwd_b_e(fb[0]),
        .valid_e(ve[0]), .valid_m(vm[0]), .valid_w(vw[0]), .stall_cnt(sc01[0]), .flush_cnt(fc01[0]));

    pipe_hazard_ctrl #(.RA_W(5), .FWD_EN(1'b0), .CNT_W(16)) u_nofwd (
        .clk(clk), .reset(reset), .dhit(dhit), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
        .load_d(load_d), .redirect_m(redirect_m), .en_f(ef[1]), .en_d(ed[1]), .en_e(ee[1]),
        .en_m(em[1]), .en_w(ew[1]), .flush_d(fd[1]), .flush_e(fe[1]), .fwd_a_e(fa[1]), .fwd_b_e(fb[1]),
        .valid_e(ve[1]), .valid_m(vm[1]), .valid_w(vw[1]), .stall_cnt(sc01[1]), .flush_cnt(fc01[1]));

    pipe_hazard_ctrl #(.RA_W(5), .FWD_EN(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .dhit(dhit), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
        .load_d(load_d), .redirect_m(redirect_m), .en_f(ef[2]), .en_d(ed[2]), .en_e(ee[2]),
        .en_m(em[2]), .en_w(ew[2]), .flush_d(fd[2]), .flush_e(fe[2]), .fwd_a_e(fa[2]), .fwd_b_e(fb[2]),
        .valid_e(ve[2]), .valid_m(vm[2]), .valid_w(vw[2]), .stall_cnt(sc2), .flush_cnt(fc2));

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.dh = 1'b1;
        return s;
    endfunction

    function automatic stim_t ins(input logic [4:0] d, input logic w, input logic l,
                                  input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub);
        stim_t s;
        s = idle();
        s.v = 1'b1; s.d = d; s.w = w; s.l = l; s.a = a; s.ua = ua; s.b = b; s.ub = ub;
        return s;
    endfunction

    function automatic exp_t xp(input logic [4:0] en, input logic [1:0] fl, input logic [1:0] a,
                                input logic [1:0] b, input logic [2:0] vld, input int s, input int f);
        exp_t r;
        r.en = en; r.fl = fl; r.fa = a; r.fb = b; r.vld = vld; r.sc = 16'(s); r.fc = 16'(f);
        return r;
    endfunction

    function automatic exp_t act(input logic [1:0] i);
        exp_t r;
        r.en  = {ef[i], ed[i], ee[i], em[i], ew[i]};
        r.fl  = {fd[i], fe[i]};
        r.fa  = fa[i];
        r.fb  = fb[i];
        r.vld = {ve[i], vm[i], vw[i]};
        if (i == 2'd2) begin
            r.sc = {14'b0, sc2};
            r.fc = {14'b0, fc2};
        end else begin
            r.sc = sc01[i[0]];
            r.fc = fc01[i[0]];
        end
        return r;
    endfunction

    task automatic drive(input stim_t s);
        reset = s.rst; dhit = s.dh; redirect_m = s.rdr; valid_d = s.v;
        rs1_d = s.a; use_rs1_d = s.ua; rs2_d = s.b; use_rs2_d = s.ub;
        rd_d = s.d; regwrite_d = s.w; load_d = s.l;
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        drive(s);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        stim_t s;
        exp_t m, want, got;
        s = ins(8, 1, 0, 7, 1, 0, 1);
        s.rst = 1'b1; s.dh = 1'b0; s.rdr = 1'b1;
        st.push_back(s);
        s.dh = 1'b1;
        st.push_back(s);
        st.push_back(idle());
        for (int r = 0; r < st.size(); r++) begin
            drive(st[r]);
            for (int i = 0; i < 3; i++) sb.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
            m = '1;
            if (r == 0) begin
                m.vld = '0; m.sc = '0; m.fc = '0;
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                want = sb.pop_front();
                got  = act(2'(i));
                vectors++;
                if ((got & m) !== (want & m)) begin
                    miscompares++;
                    $display("FAIL reset[%0d] inst%0d got=%h want=%h", r, i, got & m, want & m);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        stim_t st[$];
        exp_t ex[$];
        exp_t want, got;
        st.push_back(ins(5, 1, 0, 1, 1, 2, 1));  ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        st.push_back(ins(6, 1, 0, 5, 1, 5, 1));  ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b100, 0, 0));
        st.push_back(idle());                    ex.push_back(xp(EN_ALL, 2'b00, 2'b10, 2'b10, 3'b110, 0, 0));
        st.push_back(ins(5, 1, 0, 1, 1, 2, 1));  ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b011, 0, 0));
        st.push_back(ins(10, 1, 0, 11, 1, 12, 1)); ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b101, 0, 0));
        st.push_back(ins(6, 1, 0, 5, 1, 5, 1));  ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b110, 0, 0));
        st.push_back(idle());                    ex.push_back(xp(EN_ALL, 2'b00, 2'b01, 2'b01, 3'b111, 0, 0));
        do_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            got  = act(2'd0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL forward[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        exp_t ex[$];
        exp_t want, got;
        st.push_back(ins(7, 1, 1, 0, 0, 0, 0)); ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        st.push_back(ins(8, 1, 0, 7, 1, 0, 1)); ex.push_back(xp(EN_STL, 2'b01, 2'b00, 2'b00, 3'b100, 0, 0));
        st.push_back(ins(8, 1, 0, 7, 1, 0, 1)); ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b010, 1, 0));
        st.push_back(idle());                   ex.push_back(xp(EN_ALL, 2'b00, 2'b01, 2'b00, 3'b101, 1, 0));
        do_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            got  = act(2'd0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL load_use[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reg_zero();
        stim_t st[$];
        exp_t ex[$];
        exp_t want, got;
        st.push_back(ins(0, 1, 1, 0, 0, 0, 0)); ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        st.push_back(ins(1, 1, 0, 0, 1, 0, 1)); ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b100, 0, 0));
        st.push_back(idle());                   ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b110, 0, 0));
        st.push_back(idle());                   ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b011, 0, 0));
        do_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            got  = act(2'd0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reg_zero[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_fwd();
        stim_t st[$];
        exp_t ex[$];
        exp_t want, got;
        st.push_back(ins(5, 1, 0, 1, 1, 2, 1)); ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        st.push_back(ins(9, 1, 0, 5, 1, 1, 1)); ex.push_back(xp(EN_STL, 2'b01, 2'b00, 2'b00, 3'b100, 0, 0));
        st.push_back(ins(9, 1, 0, 5, 1, 1, 1)); ex.push_back(xp(EN_STL, 2'b01, 2'b00, 2'b00, 3'b010, 1, 0));
        st.push_back(ins(9, 1, 0, 5, 1, 1, 1)); ex.push_back(xp(EN_STL, 2'b01, 2'b00, 2'b00, 3'b001, 2, 0));
        st.push_back(ins(9, 1, 0, 5, 1, 1, 1)); ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b000, 3, 0));
        st.push_back(idle());                   ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b100, 3, 0));
        do_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            got  = act(2'd1);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL no_fwd[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_miss();
        stim_t st[$];
        exp_t ex[$];
        stim_t s;
        exp_t want, got;
        st.push_back(ins(7, 1, 1, 0, 0, 0, 0)); ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        s = ins(8, 1, 0, 7, 1, 0, 1);
        s.rdr = 1'b1;
        st.push_back(s);                        ex.push_back(xp(EN_ALL, 2'b11, 2'b00, 2'b00, 3'b100, 0, 0));
        st.push_back(idle());                   ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b010, 0, 1));
        s = ins(3, 1, 0, 1, 1, 0, 0);
        s.rdr = 1'b1;
        s.dh  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            st.push_back(s);                    ex.push_back(xp(EN_FRZ, 2'b00, 2'b00, 2'b00, 3'b001, 0, 1));
        end
        s.dh = 1'b1;
        st.push_back(s);                        ex.push_back(xp(EN_ALL, 2'b11, 2'b00, 2'b00, 3'b001, 0, 1));
        st.push_back(idle());                   ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2));
        do_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            got  = act(2'd0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL redirect_miss[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        stim_t st[$];
        exp_t ex[$];
        exp_t want, got;
        int c;
        for (int k = 0; k < 5; k++) begin
            c = (k > 3) ? 3 : k;
            st.push_back(ins(7, 1, 1, 0, 0, 0, 0));
            ex.push_back(xp(EN_ALL, 2'b00, (k == 0) ? 2'b00 : 2'b01, 2'b00, (k == 0) ? 3'b000 : 3'b101, c, 0));
            st.push_back(ins(8, 1, 0, 7, 1, 0, 1));
            ex.push_back(xp(EN_STL, 2'b01, 2'b00, 2'b00, (k == 0) ? 3'b100 : 3'b110, c, 0));
            st.push_back(ins(8, 1, 0, 7, 1, 0, 1));
            ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, (k == 0) ? 3'b010 : 3'b011, (k + 1 > 3) ? 3 : k + 1, 0));
        end
        st.push_back(idle());                   ex.push_back(xp(EN_ALL, 2'b00, 2'b01, 2'b00, 3'b101, 3, 0));
        do_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            got  = act(2'd2);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL saturation[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t st[$];
        exp_t ex[$];
        stim_t s;
        exp_t want, got;
        st.push_back(ins(5, 1, 0, 1, 1, 2, 1)); ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        st.push_back(ins(9, 1, 0, 5, 1, 1, 1)); ex.push_back(xp(EN_STL, 2'b01, 2'b00, 2'b00, 3'b100, 0, 0));
        s = ins(9, 1, 0, 5, 1, 1, 1);
        s.rst = 1'b1;
        st.push_back(s);                        ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b010, 1, 0));
        st.push_back(ins(9, 1, 0, 5, 1, 1, 1)); ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
        st.push_back(idle());                   ex.push_back(xp(EN_ALL, 2'b00, 2'b00, 2'b00, 3'b100, 0, 0));
        do_reset();
        for (int i = 0; i < st.size(); i++) begin
            drive(st[i]);
            sb.push_back(ex[i]);
            @(negedge clk);
            want = sb.pop_front();
            got  = act(2'd1);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_mid_stall[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        drive(s);
        @(posedge clk); #1;
        test_reset();
        test_forward();
        test_load_use();
        test_reg_zero();
        test_no_fwd();
        test_redirect_miss();
        test_saturation();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
